dm_cache_ctrl: RTL
==================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller.
- Sits between a CPU-side request port and a parameterized_single_port_ram backing store.
- Acts as the initiator on the RAM's clk/din/addr/we/dout interface.
- Holds tag, valid and data arrays internally in registers; 1-word lines.
- Provides saturating hit/miss counters for performance checks.

Parameters:
- ADDR_WIDTH, 12, word address width on both CPU and memory sides.
- DATA_WIDTH, 32, data word width.
- INDEX_WIDTH, 4, cache index bits (2^INDEX_WIDTH lines). Tag width = ADDR_WIDTH-INDEX_WIDTH; index = cpu_addr[INDEX_WIDTH-1:0].

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only while cpu_ready=1.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  controller idle, can accept a request.
- cpu_ack  out  1  one-cycle completion pulse for reads and writes.
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack=1 for a read.
- mem_addr  out  ADDR_WIDTH  to RAM addr.
- mem_din  out  DATA_WIDTH  to RAM din.
- mem_we  out  1  to RAM we.
- mem_dout  in  DATA_WIDTH  from RAM dout; synchronous read, reflects the addr sampled at the previous edge.
- hit_cnt  out  16  saturating read-hit count.
- miss_cnt  out  16  saturating read-miss count.

Behaviour:
- Reset (rst high at an edge), effective immediately:
  - state=IDLE; all valid bits cleared.
  - cpu_ready=1, cpu_ack=0, cpu_rdata=0.
  - mem_we=0, mem_addr=0, mem_din=0.
  - hit_cnt=0, miss_cnt=0.
  - Reset overrides any in-flight operation. A pending RAM write is abandoned only if mem_we has not yet been sampled high.
- FSM states: IDLE, RD_HIT, MISS_REQ, MISS_WAIT, RD_FILL, WR.
- cpu_ready is 1 only in IDLE. Requests while cpu_ready=0 are ignored; the CPU must hold the request.
- A request is accepted at edge N when state=IDLE and cpu_req=1. cpu_addr, cpu_we and cpu_wdata are captured into internal registers at that edge.
- Read hit (valid[idx] and tag match at edge N):
  - Go to RD_HIT.
  - cpu_ack=1 and cpu_rdata=line data during cycle N..N+1.
  - hit_cnt+1; return to IDLE at N+1.
  - Latency: 1 cycle.
- Read miss, timed from accept edge N:
  - Edge N: go to MISS_REQ, mem_addr=captured addr, mem_we=0, miss_cnt+1.
  - Edge N+1: RAM samples addr; go to MISS_WAIT.
  - Edge N+2: capture mem_dout into data[idx]; set tag[idx] and valid[idx]=1; go to RD_FILL.
  - During RD_FILL: cpu_ack=1, cpu_rdata=filled word.
  - Edge N+3: return to IDLE.
  - Latency: 3 cycles.
- Write (hit or miss):
  - Edge N: go to WR, mem_addr=addr, mem_din=wdata, mem_we=1 for exactly one cycle.
  - On a tag hit, data[idx] is updated at edge N.
  - On a miss, cache arrays are unchanged (no allocate); an aliasing line with a different tag is left intact.
  - During WR: cpu_ack=1. Edge N+1: RAM commits the write; state returns to IDLE, mem_we=0.
  - Write latency: 1 cycle. Counters are unaffected by writes.
- mem_we is never high outside WR.
- mem_addr and mem_din hold their last values when idle.
- Counters saturate at 16'hFFFF and do not wrap.
- Back-to-back requests: the CPU may assert cpu_req in the same cycle cpu_ack=1 (state returns to IDLE at that edge). The new request is accepted at the following edge.
- Read immediately after a write to the same address returns the new data: on a hit from the cache, on a miss from the RAM, which has already committed the write.

Test Plan:
- Reset, then read addr 4095 with RAM preloaded 123456789:
  - cpu_ack 3 cycles after accept, cpu_rdata=123456789.
  - miss_cnt=1, one mem read with mem_we=0.
- Repeat read of 4095:
  - cpu_ack 1 cycle after accept, data 123456789.
  - hit_cnt=1, mem_addr/mem_we unchanged.
- Write 0xDEADBEEF to 4095 (hit), then read 4095:
  - mem_we pulses exactly one cycle with mem_addr=4095, mem_din=0xDEADBEEF.
  - Read hits and returns 0xDEADBEEF.
- Write 0x55 to 0x00F, which aliases index 15 with a different tag, then read 4095:
  - Still a hit returning 0xDEADBEEF.
  - Read of 0x00F misses and returns 0x55.
- Assert rst during MISS_WAIT of a read to 0x100:
  - Next cycle cpu_ready=1, no cpu_ack, counters 0.
  - Subsequent read of 4095 misses (valid cleared).
- Hold cpu_req with changing addresses while cpu_ready=0:
  - Only the address present at the accepting IDLE edge is served.
  - cpu_ack count equals accepted-request count.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 1-word lines.
// Tag/valid/data arrays live in flops; the backing RAM has a one-cycle synchronous read.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH;
  localparam int unsigned Lines    = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StRdHit,
    StMissReq,
    StMissWait,
    StRdFill,
    StWr
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic                    mem_we_q, mem_we_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;
  logic [Lines-1:0]        valid_q, valid_d;
  logic [TagWidth-1:0]     tag_q  [Lines];
  logic [TagWidth-1:0]     tag_d  [Lines];
  logic [DATA_WIDTH-1:0]   data_q [Lines];
  logic [DATA_WIDTH-1:0]   data_d [Lines];

  logic [INDEX_WIDTH-1:0]  cpu_idx, fill_idx;
  logic [TagWidth-1:0]     cpu_tag, fill_tag;
  logic                    cpu_hit;

  assign cpu_idx  = cpu_addr[INDEX_WIDTH-1:0];
  assign cpu_tag  = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign fill_idx = addr_q[INDEX_WIDTH-1:0];
  assign fill_tag = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // Next-state, memory-port and array update logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d = cpu_addr;
          if (cpu_we) begin
            // Write-through: always forward to RAM; refresh the line only on a tag hit.
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_wdata;
            mem_we_d   = 1'b1;
            if (cpu_hit) begin
              data_d[cpu_idx] = cpu_wdata;
            end
            state_d = StWr;
          end else if (cpu_hit) begin
            rdata_d   = data_q[cpu_idx];
            hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            state_d   = StRdHit;
          end else begin
            mem_addr_d = cpu_addr;
            miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            state_d    = StMissReq;
          end
        end
      end
      StRdHit:   state_d = StIdle;
      // RAM samples mem_addr at the end of this cycle.
      StMissReq: state_d = StMissWait;
      StMissWait: begin
        data_d[fill_idx]  = mem_dout;
        tag_d[fill_idx]   = fill_tag;
        valid_d[fill_idx] = 1'b1;
        rdata_d           = mem_dout;
        state_d           = StRdFill;
      end
      StRdFill:  state_d = StIdle;
      StWr:      state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Control state, counters and valid bits with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data arrays need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_ready = (state_q == StIdle);
  assign cpu_ack   = (state_q == StRdHit) || (state_q == StRdFill) || (state_q == StWr);
  assign cpu_rdata = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
